// File: rtl/wallace_cpa_pipe.sv
// wallace_cpa_pipe: two-stage pipelined carry-propagate adder that turns the
// two carry-save rows of a Wallace tree into the final binary product.
// The low SPLIT bits are summed in stage 1 and their carry is registered.
// Stage 2 adds the high halves plus that carry.
// Valid/ready handshake on both sides, one result per clock, and a lossless
// stall when backpressure is applied.
// Optional feature macro: WALLACE_CPA_OVF_EN. When it is defined, the carry
// out of the top bit is registered and presented on ovf. When it is not
// defined, ovf is tied to 0.
module wallace_cpa_pipe #(
  parameter int WIDTH = 10,
  parameter int SPLIT = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] r1,
  input  logic [WIDTH-1:0] r2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] product,
  output logic             ovf,
  output logic             busy
);

  localparam int HI = WIDTH - SPLIT;

  logic             s1_valid;
  logic             s2_valid;
  logic [SPLIT-1:0] s1_lo;
  logic             s1_c;
  logic [HI-1:0]    s1_h1;
  logic [HI-1:0]    s1_h2;
  logic [WIDTH-1:0] product_r;
  logic             s1_adv;
  logic             s2_adv;
  logic             accept;
  logic [SPLIT:0]   lo_sum;

  // A stage may advance when its successor can take its contents. in_ready is
  // derived only from registered valids and out_ready, never from in_valid.
  assign s2_adv   = !s2_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;
  assign accept   = in_valid && s1_adv;

  assign lo_sum = (SPLIT+1)'(r1[SPLIT-1:0]) + (SPLIT+1)'(r2[SPLIT-1:0]);

  // Stage 1: low-half sum with its carry, plus the untouched high halves.
  // Data only loads on an actual accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_lo    <= '0;
      s1_c     <= 1'b0;
      s1_h1    <= '0;
      s1_h2    <= '0;
    end else if (s1_adv) begin
      s1_valid <= accept;
      if (accept) begin
        s1_lo <= lo_sum[SPLIT-1:0];
        s1_c  <= lo_sum[SPLIT];
        s1_h1 <= r1[WIDTH-1:SPLIT];
        s1_h2 <= r2[WIDTH-1:SPLIT];
      end
    end
  end

`ifdef WALLACE_CPA_OVF_EN
  logic [HI:0] hi_sum;
  logic        ovf_r;

  assign hi_sum = (HI+1)'(s1_h1) + (HI+1)'(s1_h2) + (HI+1)'(s1_c);

  // Carry out of the high sum travels alongside product and holds with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_r <= 1'b0;
    end else if (s2_adv && s1_valid) begin
      ovf_r <= hi_sum[HI];
    end
  end

  assign ovf = ovf_r;
`else
  logic [HI-1:0] hi_sum;

  assign hi_sum = s1_h1 + s1_h2 + HI'(s1_c);
  assign ovf    = 1'b0;
`endif

  // Stage 2: finish the high half and hold the result until it is consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid  <= 1'b0;
      product_r <= '0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        product_r <= {hi_sum[HI-1:0], s1_lo};
      end
    end
  end

  assign out_valid = s2_valid;
  assign product   = product_r;
  assign busy      = s1_valid | s2_valid;

endmodule

// File: tb/tb_wallace_cpa_pipe.sv
// tb_wallace_cpa_pipe: self-checking bench for wallace_cpa_pipe.
// It runs a fixed-vector table, hand-written stall/back-to-back/reset
// sequences, and randomized traffic compared against an in-order queue model.
// Expected ovf follows WALLACE_CPA_OVF_EN.
module tb_wallace_cpa_pipe;

  localparam int WIDTH = 10;

`ifdef WALLACE_CPA_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] r1;
  logic [WIDTH-1:0] r2;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] product;
  logic             ovf;
  logic             busy;

  int checks;
  int failures;

  typedef struct {
    logic [9:0] r1;
    logic [9:0] r2;
    logic [9:0] exp_product;
    logic       exp_carry;
  } vec_t;

  vec_t vecs[7];

  wallace_cpa_pipe #(.WIDTH(WIDTH), .SPLIT(5)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .r1       (r1),
    .r2       (r2),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .product  (product),
    .ovf      (ovf),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic v, input logic [9:0] a, input logic [9:0] b,
                               input logic ordy);
    in_valid  = v;
    r1        = a;
    r2        = b;
    out_ready = ordy;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Reference: unsigned sum of the rows, wrapped to 10 bits, plus its carry.
  function automatic logic [10:0] refSum(input logic [9:0] a, input logic [9:0] b);
    int s;
    s = int'(a) + int'(b);
    return 11'(s);
  endfunction

  initial begin
    int exp_q[$];
    int issued;
    int cycles;
    logic [10:0] s;
    logic [9:0] a;
    logic [9:0] b;
    logic v;
    logic ordy;
    logic exp_rdy;

    vecs[0] = '{10'd20,   10'd15,   10'd35,   1'b0};
    vecs[1] = '{10'h3FF,  10'h3FF,  10'h3FE,  1'b1};
    vecs[2] = '{10'h01F,  10'h001,  10'h020,  1'b0};
    vecs[3] = '{10'h3E0,  10'h020,  10'h000,  1'b1};
    vecs[4] = '{10'h155,  10'h0AA,  10'h1FF,  1'b0};
    vecs[5] = '{10'h200,  10'h200,  10'h000,  1'b1};
    vecs[6] = '{10'd0,    10'd0,    10'd0,    1'b0};

    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    applyStimulus(1'b0, 10'd0, 10'd0, 1'b0);

    // Reset state while held in reset and just after release.
    repeat (2) @(negedge clk);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_product",   32'(product),   32'd0);
    checkOutput("rst_ovf",       32'(ovf),       32'd0);
    checkOutput("rst_busy",      32'(busy),      32'd0);
    checkOutput("rst_in_ready",  32'(in_ready),  32'd1);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Table: single pulse, out_ready high. Stage 1 loads on the accept edge
    // and stage 2 on the next one, which is where out_valid rises.
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b1, vecs[i].r1, vecs[i].r2, 1'b1);
      #1 checkOutput($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'd1);
      @(negedge clk);
      applyStimulus(1'b0, 10'd0, 10'd0, 1'b1);
      checkOutput($sformatf("vec%0d_early_valid", i), 32'(out_valid), 32'd0);
      checkOutput($sformatf("vec%0d_busy", i), 32'(busy), 32'd1);
      @(negedge clk);
      checkOutput($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'd1);
      checkOutput($sformatf("vec%0d_product", i), 32'(product), 32'(vecs[i].exp_product));
      checkOutput($sformatf("vec%0d_ovf", i), 32'(ovf), 32'(vecs[i].exp_carry & OVF_EN));
      @(negedge clk);
      checkOutput($sformatf("vec%0d_drained", i), 32'(out_valid), 32'd0);
    end

    // Back-to-back: 31x31 then 15x0 emerge on consecutive cycles.
    applyStimulus(1'b1, 10'd500, 10'd461, 1'b1);
    #1 checkOutput("b2b_rdy0", 32'(in_ready), 32'd1);
    @(negedge clk);
    applyStimulus(1'b1, 10'd0, 10'd0, 1'b1);
    #1 checkOutput("b2b_rdy1", 32'(in_ready), 32'd1);
    @(negedge clk);
    applyStimulus(1'b0, 10'd0, 10'd0, 1'b1);
    checkOutput("b2b_valid0", 32'(out_valid), 32'd1);
    checkOutput("b2b_prod0",  32'(product),   32'd961);
    @(negedge clk);
    checkOutput("b2b_valid1", 32'(out_valid), 32'd1);
    checkOutput("b2b_prod1",  32'(product),   32'd0);
    @(negedge clk);
    checkOutput("b2b_empty", 32'(out_valid), 32'd0);

    // Stall: two pairs fill the pipe, the third is refused and the
    // presented result stays put until out_ready rises.
    applyStimulus(1'b1, 10'd100, 10'd23, 1'b0);
    #1 checkOutput("stall_rdyA", 32'(in_ready), 32'd1);
    @(negedge clk);
    applyStimulus(1'b1, 10'd200, 10'd56, 1'b0);
    #1 checkOutput("stall_rdyB", 32'(in_ready), 32'd1);
    @(negedge clk);
    applyStimulus(1'b1, 10'd7, 10'd8, 1'b0);
    for (int k = 0; k < 3; k++) begin
      #1;
      checkOutput($sformatf("stall_rdyC%0d", k), 32'(in_ready), 32'd0);
      checkOutput($sformatf("stall_hold%0d", k), 32'(product), 32'd123);
      checkOutput($sformatf("stall_valid%0d", k), 32'(out_valid), 32'd1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1 checkOutput("stall_rdy_release", 32'(in_ready), 32'd1);
    @(negedge clk);
    applyStimulus(1'b0, 10'd0, 10'd0, 1'b1);
    checkOutput("stall_outB", 32'(product), 32'd256);
    @(negedge clk);
    checkOutput("stall_outC_valid", 32'(out_valid), 32'd1);
    checkOutput("stall_outC", 32'(product), 32'd15);
    @(negedge clk);
    checkOutput("stall_empty", 32'(busy), 32'd0);

    // Reset with both stages full discards everything immediately.
    applyStimulus(1'b1, 10'd3, 10'd4, 1'b0);
    @(negedge clk);
    applyStimulus(1'b1, 10'd5, 10'd6, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 10'd0, 10'd0, 1'b0);
    checkOutput("mid_full_valid", 32'(out_valid), 32'd1);
    checkOutput("mid_full_rdy",   32'(in_ready),  32'd0);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_valid",   32'(out_valid), 32'd0);
    checkOutput("mid_rst_product", 32'(product),   32'd0);
    checkOutput("mid_rst_busy",    32'(busy),      32'd0);
    checkOutput("mid_rst_rdy",     32'(in_ready),  32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput($sformatf("mid_rst_stale%0d", k), 32'(out_valid), 32'd0);
    end

    // Randomized traffic against an in-order queue of expected {ovf,product}.
    issued = 0;
    cycles = 0;
    while ((issued < 100 || exp_q.size() != 0) && cycles < 3000) begin
      cycles++;
      v = (issued < 100) && ($urandom_range(0, 3) != 0);
      ordy = (issued >= 100) || ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 1) == 0) begin
        int pa, pb, p, x;
        pa = $urandom_range(0, 31);
        pb = $urandom_range(0, 31);
        p  = pa * pb;
        x  = $urandom_range(0, p);
        a  = 10'(x);
        b  = 10'(p - x);
      end else begin
        a = 10'($urandom_range(0, 1023));
        b = 10'($urandom_range(0, 1023));
      end
      applyStimulus(v, a, b, ordy);
      #1;
      exp_rdy = !(exp_q.size() == 2 && !ordy);
      checkOutput("rnd_in_ready", 32'(in_ready), 32'(exp_rdy));
      if (out_valid && ordy) begin
        if (exp_q.size() == 0) begin
          checkOutput("rnd_spurious_valid", 32'(out_valid), 32'd0);
        end else begin
          checkOutput("rnd_product", 32'(product), 32'(exp_q[0] & 32'h3FF));
          checkOutput("rnd_ovf", 32'(ovf), 32'(((exp_q[0] >> 10) & 1) & int'(OVF_EN)));
          void'(exp_q.pop_front());
        end
      end
      if (v && in_ready) begin
        s = refSum(a, b);
        exp_q.push_back(int'(s));
        issued++;
      end
      @(negedge clk);
    end
    checkOutput("rnd_all_issued", 32'(issued), 32'd100);
    checkOutput("rnd_queue_empty", 32'(exp_q.size()), 32'd0);
    applyStimulus(1'b0, 10'd0, 10'd0, 1'b1);
    @(negedge clk);
    checkOutput("rnd_final_busy", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
